// File: rtl/scr1_tcm_uart_loader.sv
// scr1_tcm_uart_loader
//   UART boot loader in front of TCM port B. Receives a framed image
//   (A5, LEN_LO, LEN_HI, N*4 data bytes little-endian, XOR checksum),
//   writes each assembled 32-bit word into the TCM, and releases the
//   core from reset only after a complete, checksum-valid image.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   uart_rx_i      serial input, idle high, 8N1, LSB first
//   wenb_o         single-cycle write strobe per word
//   webb_o         byte enables (always all four bytes)
//   addrb_o        word address into the TCM
//   datab_o        write data
//   core_rst_n_o   core reset, released only in DONE
//   busy_o         a frame is being received
//   done_o         image loaded and verified
//   err_o          sticky error, cleared by the next sync byte
module scr1_tcm_uart_loader #(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD      = 115200,
  parameter int SCR1_SIZE = 65536,
  localparam int AW       = $clog2(SCR1_SIZE) - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rx_i,
  output logic          wenb_o,
  output logic [3:0]    webb_o,
  output logic [AW-1:0] addrb_o,
  output logic [31:0]   datab_o,
  output logic          core_rst_n_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int HALF      = CPB / 2;
  localparam int CW        = $clog2(CPB);
  localparam int MAX_WORDS = SCR1_SIZE / 4;
  localparam logic [16:0] MAX17 = 17'(MAX_WORDS);

  // ---------------- RX front end ----------------
  // rx_s[1] is the synchronised line level, rx_s[2] its previous value
  // for falling-edge detection.
  logic [2:0]    rx_s;
  logic          rx_active;
  logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [CW-1:0] clk_cnt;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          rx_ferr;
  logic [7:0]    rx_byte;

  assign rx_byte = rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s      <= 3'b111;
      rx_active <= 1'b0;
      bit_cnt   <= 4'd0;
      clk_cnt   <= '0;
      rx_shift  <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s     <= {rx_s[1:0], uart_rx_i};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rx_s[2] && !rx_s[1]) begin
          rx_active <= 1'b1;
          bit_cnt   <= 4'd0;
          clk_cnt   <= '0;
        end
      end else if (bit_cnt == 4'd0) begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (clk_cnt == CW'(HALF - 1)) begin
          clk_cnt <= '0;
          if (rx_s[1]) rx_active <= 1'b0;
          else         bit_cnt   <= 4'd1;
        end else begin
          clk_cnt <= clk_cnt + CW'(1);
        end
      end else if (clk_cnt == CW'(CPB - 1)) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          rx_active <= 1'b0;
          rx_valid  <= rx_s[1];
          rx_ferr   <= !rx_s[1];
        end else begin
          rx_shift <= {rx_s[1], rx_shift[7:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

  // ---------------- Frame FSM ----------------
  typedef enum logic [2:0] {HUNT, LEN0, LEN1, DATA, WR, CHK, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d, len_n;
  logic [7:0]    chk_q, chk_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   buf_q, buf_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          last_word;

  // The address is never advanced past the last word, so N == MAX_WORDS
  // ends on MAX_WORDS-1 without wrapping.
  assign last_word = (17'(addr_q) + 17'd1) == {1'b0, len_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      len_q   <= 16'h0000;
      chk_q   <= 8'h00;
      idx_q   <= 2'd0;
      buf_q   <= 24'h000000;
      addr_q  <= '0;
      data_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    len_n   = {rx_byte, len_q[7:0]};
    case (state_q)
      HUNT: if (rx_valid && rx_byte == 8'hA5) begin
        err_d   = 1'b0;
        chk_d   = 8'h00;
        addr_d  = '0;
        idx_d   = 2'd0;
        state_d = LEN0;
      end
      LEN0: if (rx_valid) begin
        len_d[7:0] = rx_byte;
        state_d    = LEN1;
      end
      LEN1: if (rx_valid) begin
        len_d = len_n;
        if ({1'b0, len_n} > MAX17) state_d = ERR;
        else if (len_n == 16'h0000) state_d = CHK;
        else                        state_d = DATA;
      end
      DATA: if (rx_valid) begin
        chk_d = chk_q ^ rx_byte;
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0: buf_d[7:0]   = rx_byte;
          2'd1: buf_d[15:8]  = rx_byte;
          2'd2: buf_d[23:16] = rx_byte;
          default: begin
            data_d  = {rx_byte, buf_q};
            state_d = WR;
          end
        endcase
      end
      // wenb_o is high for exactly this one state.
      WR: begin
        if (last_word) begin
          state_d = CHK;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = DATA;
        end
      end
      CHK: if (rx_valid) state_d = (rx_byte == chk_q) ? DONE : ERR;
      DONE: state_d = DONE;
      ERR:  state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (rx_ferr && (state_q inside {LEN0, LEN1, DATA, WR, CHK})) state_d = ERR;
    if (state_d == ERR) err_d = 1'b1;
  end

  assign wenb_o       = (state_q == WR);
  assign webb_o       = 4'hF;
  assign addrb_o      = addr_q;
  assign datab_o      = data_q;
  assign busy_o       = (state_q inside {LEN0, LEN1, DATA, WR, CHK});
  assign done_o       = (state_q == DONE);
  assign core_rst_n_o = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_scr1_tcm_uart_loader.sv
// Bench for scr1_tcm_uart_loader: two instances at 16 clk/bit, one with a
// 64 KiB TCM and one with a 64-byte TCM (16 words) for address-limit cases.
module tb_scr1_tcm_uart_loader;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;

  localparam logic [8:0] RST_STAT  = 9'b0_1111_0_0_0_0;
  localparam logic [8:0] DONE_STAT = 9'b0_1111_1_0_1_0;
  localparam logic [8:0] ERR_STAT  = 9'b0_1111_0_0_0_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx0, rx1;
  logic wenb0, core0, busy0, done0, err0;
  logic [3:0] webb0;
  logic [13:0] addr0;
  logic [31:0] data0;
  logic wenb1, core1, busy1, done1, err1;
  logic [3:0] webb1;
  logic [3:0] addr1;
  logic [31:0] data1;

  scr1_tcm_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCR1_SIZE(65536)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rx0), .wenb_o(wenb0), .webb_o(webb0),
    .addrb_o(addr0), .datab_o(data0), .core_rst_n_o(core0), .busy_o(busy0),
    .done_o(done0), .err_o(err0));

  scr1_tcm_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCR1_SIZE(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rx1), .wenb_o(wenb1), .webb_o(webb1),
    .addrb_o(addr1), .datab_o(data1), .core_rst_n_o(core1), .busy_o(busy1),
    .done_o(done1), .err_o(err1));

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;
  int total = 0;
  int bad = 0;
  logic [31:0] img [0:15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] stat0();
    return {wenb0, webb0, core0, busy0, done0, err0};
  endfunction

  function automatic logic [8:0] stat1();
    return {wenb1, webb1, core1, busy1, done1, err1};
  endfunction

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wenb0) begin
      check("wr0_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("wr0_addr", 64'(addr0), 64'(e0.addr));
        check("wr0_data", 64'(data0), 64'(e0.data));
      end
    end
    if (wenb1) begin
      check("wr1_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("wr1_addr", 64'(addr1), 64'(e1.addr));
        check("wr1_data", 64'(data1), 64'(e1.data));
      end
    end
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(sel, fr[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(sel, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Sends a full frame from img[]; the checksum is computed here unless
  // chk_force >= 0. Expected writes are queued as each word is sent.
  task automatic send_frame(input int sel, input int len, input int chk_force);
    logic [7:0] chk;
    logic [31:0] w;
    int maxw;
    maxw = (sel == 0) ? 16384 : 16;
    chk = 8'h00;
    send_byte(sel, 8'hA5, 1'b1);
    send_byte(sel, 8'(len), 1'b1);
    send_byte(sel, 8'(len >> 8), 1'b1);
    if (len > maxw) begin
      check("hdr_reject_err", 64'((sel == 0) ? err0 : err1), 64'd1);
      repeat (20) @(negedge clk);
      return;
    end
    check("hdr_busy", 64'((sel == 0) ? busy0 : busy1), 64'd1);
    check("hdr_err_clr", 64'((sel == 0) ? err0 : err1), 64'd0);
    for (int i = 0; i < len; i++) begin
      w = img[i];
      if (sel == 0) q0.push_back('{addr: i, data: w});
      else          q1.push_back('{addr: i, data: w});
      for (int k = 0; k < 4; k++) begin
        chk = chk ^ w[8*k +: 8];
        send_byte(sel, w[8*k +: 8], 1'b1);
      end
    end
    send_byte(sel, (chk_force < 0) ? chk : 8'(chk_force), 1'b1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx0   = 1'b1;
    rx1   = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_stat0", 64'(stat0()), 64'(RST_STAT));
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_data0", 64'(data0), 64'd0);
    check("rst_stat1", 64'(stat1()), 64'(RST_STAT));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic two-word load
    img[0] = 32'h0140_0613;
    img[1] = 32'hDEAD_BEEF;
    send_frame(0, 2, -1);
    check("t1_done", 64'(stat0()), 64'(DONE_STAT));
    check("t1_drain", 64'(q0.size()), 64'd0);
    check("t1_addr_hold", 64'(addr0), 64'd1);

    // Bad checksum, then a good reload clears the error
    do_reset();
    send_frame(0, 2, 0);
    check("t2_err", 64'(stat0()), 64'(ERR_STAT));
    check("t2_drain", 64'(q0.size()), 64'd0);
    send_frame(0, 2, -1);
    check("t2_reload", 64'(stat0()), 64'(DONE_STAT));
    check("t2_drain2", 64'(q0.size()), 64'd0);

    // Leading junk bytes are ignored
    do_reset();
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_junk_idle", 64'(stat0()), 64'(RST_STAT));
    send_frame(0, 2, -1);
    check("t3_done", 64'(stat0()), 64'(DONE_STAT));
    check("t3_drain", 64'(q0.size()), 64'd0);

    // Short glitch, then a framing error mid-word
    do_reset();
    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_glitch", 64'(stat0()), 64'(RST_STAT));
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    check("t4_busy", 64'(busy0), 64'd1);
    send_byte(0, 8'h13, 1'b1);
    send_byte(0, 8'h06, 1'b1);
    send_byte(0, 8'h40, 1'b0);
    repeat (CPB) @(negedge clk);
    check("t4_ferr", 64'(stat0()), 64'(ERR_STAT));
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'hEF, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_after", 64'(stat0()), 64'(ERR_STAT));
    check("t4_drain", 64'(q0.size()), 64'd0);

    // 16-word TCM: one word too many, exactly full, and empty image
    do_reset();
    send_frame(1, 17, -1);
    check("t5_over", 64'(stat1()), 64'(ERR_STAT));
    check("t5_over_drain", 64'(q1.size()), 64'd0);
    do_reset();
    for (int i = 0; i < 16; i++) img[i] = 32'(32'h0102_0304 * (i + 1)) ^ 32'hA5A5_0000;
    send_frame(1, 16, -1);
    check("t5_full", 64'(stat1()), 64'(DONE_STAT));
    check("t5_full_drain", 64'(q1.size()), 64'd0);
    check("t5_last_addr", 64'(addr1), 64'd15);
    do_reset();
    send_frame(1, 0, 0);
    check("t5_empty", 64'(stat1()), 64'(DONE_STAT));
    check("t5_empty_drain", 64'(q1.size()), 64'd0);

    // Asynchronous reset in the middle of a word
    do_reset();
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    check("t6_busy", 64'(busy0), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_stat", 64'(stat0()), 64'(RST_STAT));
    check("t6_async_addr", 64'(addr0), 64'd0);
    check("t6_async_data", 64'(data0), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(0, 8'h33, 1'b1);
    send_byte(0, 8'h44, 1'b1);
    send_byte(0, 8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_hunt", 64'(stat0()), 64'(RST_STAT));
    check("t6_drain", 64'(q0.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
